// File: rtl/plugboard_unit.sv
// Run-time loadable plugboard stage: pair table, sequential duplicate check,
// and a one-cycle registered forward/backward substitution with valid/ready.
module plugboard_unit #(
  parameter int SYM_W     = 6,
  parameter int NUM_PAIRS = 16,
  parameter int PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [PAIR_W-1:0] cfg_pair,
  input  logic [SYM_W-1:0]  cfg_a,
  input  logic [SYM_W-1:0]  cfg_b,
  input  logic              cfg_en,
  input  logic              cfg_commit,
  input  logic              cfg_clear,
  output logic              cfg_busy,
  output logic              cfg_ok,
  output logic              cfg_err,
  output logic [PAIR_W-1:0] err_pair,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SYM_W-1:0]  in_sym,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic              out_hit
);

  typedef enum logic [1:0] {UNCFG, CHECK, ACTIVE, FAULT} state_t;

  state_t state, state_nxt;

  logic [SYM_W-1:0]     pair_a [NUM_PAIRS];
  logic [SYM_W-1:0]     pair_b [NUM_PAIRS];
  logic [NUM_PAIRS-1:0] pair_en;
  logic [PAIR_W-1:0]    chk_idx;
  logic                 conflict;
  logic                 chk_last;
  logic                 wr_ok;
  logic                 xfer;
  logic [SYM_W-1:0]     lk_x;
  logic [SYM_W-1:0]     lk_sym;
  logic                 lk_hit;
  logic                 vld_p0;
  logic [SYM_W-1:0]     sym_p0;
  logic                 hit_p0;

  // Reflection about 2^SYM_W-1 is exactly a bitwise inversion.
  function automatic logic [SYM_W-1:0] reflect(input logic [SYM_W-1:0] s);
    return ~s;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= UNCFG;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_ok     = 1'b0;
    if (cfg_clear) begin
      state_nxt = UNCFG;
    end else begin
      case (state)
        UNCFG: begin
          wr_ok = cfg_we;
          if (cfg_commit) state_nxt = CHECK;
        end
        CHECK: begin
          if (conflict)      state_nxt = FAULT;
          else if (chk_last) state_nxt = ACTIVE;
        end
        ACTIVE: state_nxt = ACTIVE;
        FAULT: begin
          if (cfg_we) begin
            wr_ok     = 1'b1;
            state_nxt = UNCFG;
          end else if (cfg_commit) begin
            state_nxt = CHECK;
          end
        end
        default: state_nxt = UNCFG;
      endcase
    end
  end

  // Pair k against itself and every later enabled pair.
  always_comb begin
    conflict = 1'b0;
    if (pair_en[chk_idx]) begin
      if (pair_a[chk_idx] == pair_b[chk_idx]) conflict = 1'b1;
      for (int j = 0; j < NUM_PAIRS; j++) begin
        if (j > int'(chk_idx) && pair_en[j]) begin
          if (pair_a[chk_idx] == pair_a[j] || pair_a[chk_idx] == pair_b[j] ||
              pair_b[chk_idx] == pair_a[j] || pair_b[chk_idx] == pair_b[j])
            conflict = 1'b1;
        end
      end
    end
  end

  assign chk_last = (int'(chk_idx) == NUM_PAIRS - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_idx  <= '0;
      err_pair <= '0;
    end else begin
      if (state != CHECK) chk_idx <= '0;
      else                chk_idx <= chk_idx + 1'b1;
      if (state != CHECK && state_nxt == CHECK)
        err_pair <= '0;
      else if (state == CHECK && state_nxt == FAULT)
        err_pair <= chk_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cfg_clear) begin
      pair_en <= '0;
    end else if (wr_ok && int'(cfg_pair) < NUM_PAIRS) begin
      pair_en[cfg_pair] <= cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && int'(cfg_pair) < NUM_PAIRS) begin
      pair_a[cfg_pair] <= cfg_a;
      pair_b[cfg_pair] <= cfg_b;
    end
  end

  // Descending scan so the lowest pair, and its a side, win any tie.
  always_comb begin
    lk_x   = in_mode ? reflect(in_sym) : in_sym;
    lk_sym = lk_x;
    lk_hit = 1'b0;
    for (int p = NUM_PAIRS - 1; p >= 0; p--) begin
      if (pair_en[p] && lk_x == pair_b[p]) begin
        lk_sym = pair_a[p];
        lk_hit = 1'b1;
      end
      if (pair_en[p] && lk_x == pair_a[p]) begin
        lk_sym = pair_b[p];
        lk_hit = 1'b1;
      end
    end
  end

  assign in_ready = (state == ACTIVE) && !cfg_clear && (!vld_p0 || out_ready);
  assign xfer     = in_valid && in_ready;

  // Stage p0: registered lookup result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      sym_p0 <= '0;
      hit_p0 <= 1'b0;
    end else if (cfg_clear) begin
      vld_p0 <= 1'b0;
    end else if (xfer) begin
      vld_p0 <= 1'b1;
      sym_p0 <= lk_sym;
      hit_p0 <= lk_hit;
    end else if (out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_valid = vld_p0;
  assign out_sym   = sym_p0;
  assign out_hit   = hit_p0;
  assign cfg_busy  = (state == CHECK);
  assign cfg_ok    = (state == ACTIVE);
  assign cfg_err   = (state == FAULT);

endmodule

// File: tb/tb_plugboard_unit.sv
// Bench for plugboard_unit: directed table scenarios plus randomized tables and
// traffic, scored against a pair-list reference model.
module tb_plugboard_unit;
  localparam int SYM_W     = 6;
  localparam int NUM_PAIRS = 4;
  localparam int PAIR_W    = 2;
  localparam int SYM_MAX   = (1 << SYM_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [PAIR_W-1:0] cfg_pair = '0;
  logic [SYM_W-1:0]  cfg_a = '0;
  logic [SYM_W-1:0]  cfg_b = '0;
  logic              cfg_en = 1'b0;
  logic              cfg_commit = 1'b0;
  logic              cfg_clear = 1'b0;
  logic              cfg_busy, cfg_ok, cfg_err;
  logic [PAIR_W-1:0] err_pair;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SYM_W-1:0]  in_sym = '0;
  logic              in_mode = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [SYM_W-1:0]  out_sym;
  logic              out_hit;

  always #5 clk = ~clk;

  plugboard_unit #(.SYM_W(SYM_W), .NUM_PAIRS(NUM_PAIRS), .PAIR_W(PAIR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_pair(cfg_pair), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_en(cfg_en),
    .cfg_commit(cfg_commit), .cfg_clear(cfg_clear),
    .cfg_busy(cfg_busy), .cfg_ok(cfg_ok), .cfg_err(cfg_err), .err_pair(err_pair),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_hit(out_hit)
  );

  int n_checks = 0;
  int n_errors = 0;

  int ref_a [NUM_PAIRS];
  int ref_b [NUM_PAIRS];
  bit ref_en [NUM_PAIRS];
  bit m_ok = 1'b0;

  int stim_sym [$];
  bit stim_mode [$];
  int exp_sym [$];
  bit exp_hit [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_lookup(input int sym, input bit mode, output int res, output bit hit);
    int x;
    x = mode ? (SYM_MAX - sym) : sym;
    res = x;
    hit = 1'b0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (!hit && ref_en[p]) begin
        if (x == ref_a[p]) begin res = ref_b[p]; hit = 1'b1; end
        else if (x == ref_b[p]) begin res = ref_a[p]; hit = 1'b1; end
      end
    end
  endfunction

  // First enabled pair whose symbols repeat inside itself or in a later enabled pair.
  function automatic int ref_conflict();
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (ref_en[k]) begin
        if (ref_a[k] == ref_b[k]) return k;
        for (int j = k + 1; j < NUM_PAIRS; j++) begin
          if (ref_en[j] && (ref_a[j] == ref_a[k] || ref_a[j] == ref_b[k] ||
                            ref_b[j] == ref_a[k] || ref_b[j] == ref_b[k]))
            return k;
        end
      end
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NUM_PAIRS; p++) ref_en[p] = 1'b0;
    m_ok = 1'b0;
  endtask

  task automatic do_clear();
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    model_clear();
  endtask

  task automatic cfg_write(input int p, input int a, input int b, input bit en, input bit commit);
    cfg_we = 1'b1; cfg_pair = PAIR_W'(p); cfg_a = SYM_W'(a); cfg_b = SYM_W'(b);
    cfg_en = en; cfg_commit = commit;
    @(negedge clk);
    cfg_we = 1'b0; cfg_commit = 1'b0;
    ref_a[p] = a; ref_b[p] = b; ref_en[p] = en;
  endtask

  task automatic wait_check(input string tag);
    int k;
    int n;
    k = ref_conflict();
    n = 0;
    while (cfg_busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n, (k < 0) ? NUM_PAIRS : k + 1);
    check({tag, "_ok"}, cfg_ok, (k < 0));
    check({tag, "_err"}, cfg_err, (k >= 0));
    if (k >= 0) check({tag, "_err_pair"}, err_pair, k);
    m_ok = (k < 0);
  endtask

  task automatic commit_only(input string tag);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    wait_check(tag);
  endtask

  task automatic push_stim(input int sym, input bit mode);
    stim_sym.push_back(sym);
    stim_mode.push_back(mode);
  endtask

  task automatic run_stream(input string tag, input bit rand_bp, input int stall_at, input int stall_len);
    int cyc;
    bit have_hold;
    logic [SYM_W-1:0] hold_sym;
    logic hold_hit;
    int r;
    bit h;
    cyc = 0;
    have_hold = 1'b0;
    hold_sym = '0;
    hold_hit = 1'b0;
    while ((stim_sym.size() > 0 || exp_sym.size() > 0) && cyc < 600) begin
      in_valid = (stim_sym.size() > 0) && (!rand_bp || $urandom_range(0, 3) != 0);
      if (in_valid) begin
        in_sym  = SYM_W'(stim_sym[0]);
        in_mode = stim_mode[0];
      end
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len) &&
                  (!rand_bp || $urandom_range(0, 2) != 0);
      #1;
      if (have_hold) begin
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_sym"}, out_sym, hold_sym);
        check({tag, "_hold_hit"}, out_hit, hold_hit);
      end
      check({tag, "_in_ready"}, in_ready, m_ok && (!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_sym.size() == 0) begin
          check({tag, "_extra_output"}, 1, 0);
        end else begin
          check({tag, "_sym"}, out_sym, exp_sym.pop_front());
          check({tag, "_hit"}, out_hit, exp_hit.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        ref_lookup(stim_sym.pop_front(), stim_mode.pop_front(), r, h);
        exp_sym.push_back(r);
        exp_hit.push_back(h);
      end
      have_hold = out_valid && !out_ready;
      hold_sym  = out_sym;
      hold_hit  = out_hit;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check({tag, "_pending_results"}, exp_sym.size() + stim_sym.size(), 0);
    check({tag, "_drained_valid"}, out_valid, 0);
    stim_sym.delete(); stim_mode.delete(); exp_sym.delete(); exp_hit.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    for (int p = 0; p < NUM_PAIRS; p++) begin ref_a[p] = 0; ref_b[p] = 0; end
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", cfg_busy, 0);
    check("rst_ok", cfg_ok, 0);
    check("rst_err", cfg_err, 0);
    check("rst_err_pair", err_pair, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sym", out_sym, 0);
    check("rst_out_hit", out_hit, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic table, forward then backward traffic.
    do_clear();
    cfg_write(0, 3, 10, 1, 0);
    cfg_write(1, 20, 7, 1, 0);
    commit_only("basic");
    push_stim(3, 0); push_stim(10, 0); push_stim(5, 0);
    run_stream("fwd", 0, -10, 0);
    push_stim(53, 1); push_stim(63, 1);
    run_stream("bwd", 0, -10, 0);

    // Backpressure mid-stream.
    push_stim(3, 0); push_stim(7, 0); push_stim(44, 1); push_stim(20, 0);
    run_stream("stall", 0, 2, 3);

    // Writes and commits in ACTIVE are ignored.
    cfg_we = 1'b1; cfg_pair = 0; cfg_a = 1; cfg_b = 2; cfg_en = 1; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; cfg_commit = 1'b0;
    check("active_ignore_busy", cfg_busy, 0);
    check("active_ignore_ok", cfg_ok, 1);
    push_stim(3, 0); push_stim(1, 0);
    run_stream("active_ignore", 0, -10, 0);

    // b-vs-b conflict, then repair from FAULT.
    do_clear();
    cfg_write(0, 3, 10, 1, 0);
    cfg_write(2, 9, 10, 1, 0);
    commit_only("dup");
    cfg_write(2, 9, 11, 1, 0);
    check("fault_wr_err_clr", cfg_err, 0);
    check("fault_wr_not_ok", cfg_ok, 0);
    commit_only("repair");

    // Self-paired symbol.
    do_clear();
    cfg_write(0, 3, 10, 1, 0);
    cfg_write(1, 12, 12, 1, 0);
    commit_only("self");
    commit_only("recheck");

    // Disabled duplicate; write and commit land in the same cycle.
    do_clear();
    cfg_write(0, 3, 10, 1, 0);
    cfg_write(1, 3, 5, 0, 1);
    wait_check("disabled");
    push_stim(3, 0); push_stim(5, 0); push_stim(60, 1);
    run_stream("disabled", 0, -10, 0);

    // Clear while a result is stalled.
    in_valid = 1'b1; in_sym = 3; in_mode = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("clr_pre_valid", out_valid, 1);
    check("clr_pre_sym", out_sym, 10);
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    model_clear();
    check("clr_out_valid", out_valid, 0);
    check("clr_ok", cfg_ok, 0);
    check("clr_in_ready", in_ready, 0);
    out_ready = 1'b1;

    // Reset during CHECK.
    cfg_write(0, 3, 10, 1, 1);
    check("rstchk_busy", cfg_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    check("rstchk_busy0", cfg_busy, 0);
    check("rstchk_ok0", cfg_ok, 0);
    check("rstchk_err0", cfg_err, 0);
    check("rstchk_err_pair0", err_pair, 0);
    check("rstchk_valid0", out_valid, 0);
    check("rstchk_hit0", out_hit, 0);
    commit_only("after_rst");
    push_stim(3, 0); push_stim(10, 0);
    run_stream("after_rst", 0, -10, 0);

    // Randomized tables and traffic.
    for (int r = 0; r < 8; r++) begin
      int tries;
      do_clear();
      for (int p = 0; p < NUM_PAIRS; p++)
        cfg_write(p, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3) != 0,
                  (p == NUM_PAIRS - 1) && (r % 2 == 1));
      if (r % 2 == 1) wait_check("rnd");
      else commit_only("rnd");
      tries = 0;
      while (!m_ok && tries < NUM_PAIRS) begin
        cfg_write(ref_conflict(), 0, 0, 0, 0);
        check("rnd_fix_err_clr", cfg_err, 0);
        commit_only("rnd_fix");
        tries++;
      end
      for (int i = 0; i < 30; i++) begin
        int s;
        bit m;
        s = $urandom_range(0, 15);
        m = $urandom_range(0, 1);
        if (m && $urandom_range(0, 3) != 0) s = SYM_MAX - s;
        push_stim(s, m);
      end
      run_stream("rnd_stream", 1, -10, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
